// File: rtl/delay_pipe_credit_ctrl.sv
// delay_pipe_credit_ctrl: credit-based admission, per-stage valid tags and output FIFO
// for a fixed-latency, non-stallable delay datapath.
module delay_pipe_credit_ctrl #(
  parameter int DATA_BW    = 10,
  parameter int LAT        = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_BW     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_flush,
  input  logic               i_valid,
  output logic               o_ready,
  output logic               o_pipe_load,
  output logic [LAT-1:0]     o_stage_vld,
  input  logic [DATA_BW-1:0] i_pipe_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [DATA_BW-1:0] o_data,
  output logic [CNT_BW-1:0]  o_credit,
  output logic               o_busy
);
  localparam int PTR_BW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  logic [LAT-1:0]     vld_q, vld_d;
  logic [PTR_BW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_BW-1:0]  count_q, count_d, credit_q, credit_d;
  logic [DATA_BW-1:0] mem_q [FIFO_DEPTH];
  logic               accept, wr, pop;
  function automatic logic [PTR_BW-1:0] inc(input logic [PTR_BW-1:0] p);
    return p == PTR_BW'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign o_ready     = credit_q != '0;
  assign o_pipe_load = accept;
  assign o_stage_vld = vld_q;
  assign o_valid     = count_q != '0;
  assign o_data      = o_valid ? mem_q[rd_ptr_q] : '0;
  assign o_credit    = credit_q;
  assign o_busy      = (|vld_q) | (count_q != '0);
  always_comb begin
    accept   = i_valid & o_ready;
    wr       = vld_q[LAT-1];
    pop      = o_valid & i_ready;
    vld_d    = (vld_q << 1) | LAT'(accept);
    wr_ptr_d = wr ? inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_BW'(wr) - CNT_BW'(pop);
    credit_d = credit_q - CNT_BW'(accept) + CNT_BW'(pop);
  end
  // flush and reset clear the same state; stale datapath data is never written since its tags vanish
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      credit_q <= CNT_BW'(FIFO_DEPTH);
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      credit_q <= credit_d;
    end
  end
  always_ff @(posedge i_clk) begin
    if (wr && !i_flush && !i_rst) mem_q[wr_ptr_q] <= i_pipe_data;
  end
  assert property (@(posedge i_clk) disable iff (i_rst || i_flush)
    !(wr && !pop && count_q == CNT_BW'(FIFO_DEPTH)));
endmodule

// File: tb/tb_delay_pipe_credit_ctrl.sv
// tb_delay_pipe_credit_ctrl: scoreboard bench with a 2-stage delay datapath model.
module tb_delay_pipe_credit_ctrl;
  localparam int DATA_BW = 10, LAT = 2, DEPTH = 4, CNT_BW = 3;
  logic               clk = 0, rst = 1, flush = 0, valid = 0, ready = 0;
  logic [DATA_BW-1:0] din = '0;
  logic [DATA_BW-1:0] pipe [LAT];
  logic               o_ready, o_pipe_load, o_valid, o_busy;
  logic [LAT-1:0]     o_stage_vld;
  logic [DATA_BW-1:0] o_data;
  logic [CNT_BW-1:0]  o_credit;
  logic [DATA_BW-1:0] sb [$];
  int passed = 0, total = 0, accepts = 0;

  delay_pipe_credit_ctrl #(.DATA_BW(DATA_BW), .LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(o_ready),
    .o_pipe_load(o_pipe_load), .o_stage_vld(o_stage_vld), .i_pipe_data(pipe[LAT-1]),
    .o_valid(o_valid), .i_ready(ready), .o_data(o_data), .o_credit(o_credit), .o_busy(o_busy));

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    pipe[0] <= din;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst || flush) sb.delete();
    else begin
      if (o_valid && ready) begin
        if (sb.size() == 0) chk("unexpected_pop", o_valid, 0);
        else chk("pop_data", o_data, sb.pop_front());
      end
      if (valid && o_ready) begin
        sb.push_back(din);
        accepts++;
      end
    end
  end

  task automatic check_idle(input string nm);
    chk({nm, "_ready"}, o_ready, 1);
    chk({nm, "_valid"}, o_valid, 0);
    chk({nm, "_stage"}, o_stage_vld, 0);
    chk({nm, "_credit"}, o_credit, DEPTH);
    chk({nm, "_busy"}, o_busy, 0);
    chk({nm, "_data"}, o_data, 0);
  endtask

  initial begin
    tick();
    tick();
    check_idle("rst");
    rst = 0;
    ready = 1;
    valid = 1; din = 100;
    tick();
    valid = 0;
    chk("A_stage_c1", o_stage_vld, 1);
    chk("A_credit_c1", o_credit, 3);
    chk("A_busy_c1", o_busy, 1);
    tick();
    chk("A_stage_c2", o_stage_vld, 2);
    chk("A_valid_c2", o_valid, 0);
    tick();
    chk("A_stage_c3", o_stage_vld, 0);
    chk("A_valid_c3", o_valid, 1);
    chk("A_credit_c3", o_credit, 3);
    tick();
    chk("A_valid_c4", o_valid, 0);
    chk("A_busy_c4", o_busy, 0);
    chk("A_credit_c4", o_credit, 4);
    for (int i = 0; i < 8; i++) begin
      chk("B_ready", o_ready, 1);
      chk("B_valid", o_valid, int'(i >= 3));
      valid = 1; din = DATA_BW'(i + 1);
      tick();
    end
    valid = 0;
    chk("B_credit_settle", o_credit, 1);
    repeat (3) tick();
    chk("B_busy_end", o_busy, 0);
    chk("B_credit_end", o_credit, 4);
    ready = 0;
    accepts = 0;
    for (int i = 0; i < 8; i++) begin
      chk("C_ready", o_ready, int'(i < 4));
      valid = 1; din = DATA_BW'(11 + i);
      tick();
    end
    chk("C_accepts", accepts, 4);
    chk("C_credit", o_credit, 0);
    chk("C_valid", o_valid, 1);
    chk("D_ready_full", o_ready, 0);
    ready = 1; valid = 1; din = 50;
    tick();
    chk("D_credit", o_credit, 1);
    chk("D_ready", o_ready, 1);
    for (int i = 0; i < 4; i++) begin
      din = DATA_BW'(51 + i);
      tick();
    end
    valid = 0;
    repeat (8) tick();
    chk("D_busy_end", o_busy, 0);
    ready = 0;
    for (int i = 0; i < 4; i++) begin
      valid = 1; din = DATA_BW'(60 + i);
      tick();
    end
    valid = 0;
    chk("E_stage_pre", o_stage_vld, 3);
    chk("E_valid_pre", o_valid, 1);
    chk("E_credit_pre", o_credit, 0);
    flush = 1;
    tick();
    flush = 0;
    chk("E_valid", o_valid, 0);
    chk("E_stage", o_stage_vld, 0);
    chk("E_credit", o_credit, 4);
    chk("E_busy", o_busy, 0);
    ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("E_no_stale", o_valid, 0);
    end
    valid = 1; din = 77;
    tick();
    valid = 0;
    repeat (4) tick();
    chk("E_busy_end", o_busy, 0);
    for (int i = 0; i < 4; i++) begin
      valid = 1; din = DATA_BW'(200 + i);
      tick();
    end
    din = 204;
    rst = 1;
    tick();
    rst = 0;
    valid = 0;
    check_idle("F_rst");
    for (int i = 0; i < 3; i++) begin
      valid = 1; din = DATA_BW'(300 + i);
      tick();
    end
    valid = 0;
    repeat (5) tick();
    chk("F_busy_end", o_busy, 0);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
